// File: rtl/a5_1_decipher_if.sv
// Handshake and data bundle between an A5/1 decipher engine and its controller.
// The master drives the frame request; the slave answers with status and plaintext.
interface a5_1_decipher_if #(
    parameter int KEY_W   = 64,
    parameter int FRAME_W = 22,
    parameter int MSG_W   = 256
);
    logic               start;
    logic [KEY_W-1:0]   key;
    logic [FRAME_W-1:0] frame;
    logic [MSG_W-1:0]   ct;
    logic               busy;
    logic               done;
    logic [MSG_W-1:0]   pt;
    logic               ks_bit;
    logic               ks_valid;

    modport master (
        output start, key, frame, ct,
        input  busy, done, pt, ks_bit, ks_valid
    );

    modport slave (
        input  start, key, frame, ct,
        output busy, done, pt, ks_bit, ks_valid
    );
endinterface

// File: rtl/a5_1_decipher.sv
// Bit-serial receive-side A5/1: key/frame load, 100 discarded mixing steps, then one
// keystream bit per clock XORed into the captured ciphertext to recover the plaintext.
module a5_1_decipher #(
    parameter int KEY_W      = 64,
    parameter int FRAME_W    = 22,
    parameter int MIX_CYCLES = 100,
    parameter int MSG_W      = 256
) (
    input logic            clk,
    input logic            rst,
    a5_1_decipher_if.slave bus
);

    localparam int MAX_KF  = (KEY_W > FRAME_W) ? KEY_W : FRAME_W;
    localparam int MAX_KFM = (MAX_KF > MIX_CYCLES) ? MAX_KF : MIX_CYCLES;
    localparam int MAX_ALL = (MAX_KFM > MSG_W) ? MAX_KFM : MSG_W;
    localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_F,
        MIX,
        STREAM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [18:0]        r1_q, r1_d;
    logic [21:0]        r2_q, r2_d;
    logic [22:0]        r3_q, r3_d;
    logic [KEY_W-1:0]   keySh_q, keySh_d;
    logic [FRAME_W-1:0] frameSh_q, frameSh_d;
    logic [MSG_W-1:0]   ctSh_q, ctSh_d;
    logic [MSG_W-1:0]   ptSh_q, ptSh_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ksBit_q, ksBit_d;
    logic               ksValid_q, ksValid_d;

    logic        loadBit;
    logic        majorityMode;
    logic        maj;
    logic        en1, en2, en3;
    logic        fb1, fb2, fb3;
    logic [18:0] r1Step;
    logic [21:0] r2Step;
    logic [22:0] r3Step;
    logic        z;

    // Captured key/frame are consumed LSB first by shifting them right each load step.
    assign loadBit = (state_q == LOAD_K) ? keySh_q[0] :
                     (state_q == LOAD_F) ? frameSh_q[0] : 1'b0;

    assign majorityMode = (state_q == MIX) || (state_q == STREAM);
    assign maj = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);

    assign en1 = !majorityMode || (r1_q[8]  == maj);
    assign en2 = !majorityMode || (r2_q[10] == maj);
    assign en3 = !majorityMode || (r3_q[10] == maj);

    assign fb1 = r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18] ^ loadBit;
    assign fb2 = r2_q[20] ^ r2_q[21] ^ loadBit;
    assign fb3 = r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22] ^ loadBit;

    assign r1Step = en1 ? {r1_q[17:0], fb1} : r1_q;
    assign r2Step = en2 ? {r2_q[20:0], fb2} : r2_q;
    assign r3Step = en3 ? {r3_q[21:0], fb3} : r3_q;

    // Keystream bit comes from the registers as they will be after this step.
    assign z = r1Step[18] ^ r2Step[21] ^ r3Step[22];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        keySh_d   = keySh_q;
        frameSh_d = frameSh_q;
        ctSh_d    = ctSh_q;
        ptSh_d    = ptSh_q;
        busy_d    = busy_q;
        done_d    = done_q;
        ksBit_d   = ksBit_q;
        ksValid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    keySh_d   = bus.key;
                    frameSh_d = bus.frame;
                    ctSh_d    = bus.ct;
                    r1_d      = '0;
                    r2_d      = '0;
                    r3_d      = '0;
                    ptSh_d    = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = LOAD_K;
                end
            end
            LOAD_K: begin
                r1_d    = r1Step;
                r2_d    = r2Step;
                r3_d    = r3Step;
                keySh_d = keySh_q >> 1;
                if (cnt_q == CNT_W'(KEY_W - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_F;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD_F: begin
                r1_d      = r1Step;
                r2_d      = r2Step;
                r3_d      = r3Step;
                frameSh_d = frameSh_q >> 1;
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    cnt_d   = '0;
                    state_d = MIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MIX: begin
                r1_d = r1Step;
                r2_d = r2Step;
                r3_d = r3Step;
                if (cnt_q == CNT_W'(MIX_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STREAM: begin
                r1_d      = r1Step;
                r2_d      = r2Step;
                r3_d      = r3Step;
                // Plaintext enters at the MSB; after MSG_W steps bit i sits at position i.
                ptSh_d    = {ctSh_q[0] ^ z, ptSh_q[MSG_W-1:1]};
                ctSh_d    = ctSh_q >> 1;
                ksBit_d   = z;
                ksValid_d = 1'b1;
                if (cnt_q == CNT_W'(MSG_W - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
            keySh_q   <= '0;
            frameSh_q <= '0;
            ctSh_q    <= '0;
            ptSh_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ksBit_q   <= 1'b0;
            ksValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            r3_q      <= r3_d;
            keySh_q   <= keySh_d;
            frameSh_q <= frameSh_d;
            ctSh_q    <= ctSh_d;
            ptSh_q    <= ptSh_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ksBit_q   <= ksBit_d;
            ksValid_q <= ksValid_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pt       = ptSh_q;
    assign bus.ks_bit   = ksBit_q;
    assign bus.ks_valid = ksValid_q;

endmodule

// File: tb/tb_a5_1_decipher.sv
// Scoreboard bench for a5_1_decipher: stimulus queues expected plaintext per frame,
// a negedge monitor checks plaintext, latency and the keystream pulses when done rises.
module tb_a5_1_decipher;

    localparam int LATENCY = 442;

    typedef struct {
        logic [255:0] pt;
        logic [255:0] ct;
        int           startCyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    exp_t sb[$];

    int           ksCount;
    logic [255:0] ksBits;
    logic         prevDone;

    logic [63:0]  keyB;
    logic [21:0]  frameB;
    logic [255:0] ksB;
    logic [63:0]  keyG;
    logic [21:0]  frameG;
    logic [255:0] ctG;
    logic [255:0] ctE;
    logic [255:0] patA5;
    int           startCycR;

    a5_1_decipher_if #(.KEY_W(64), .FRAME_W(22), .MSG_W(256)) bus ();

    a5_1_decipher #(
        .KEY_W(64),
        .FRAME_W(22),
        .MIX_CYCLES(100),
        .MSG_W(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference A5/1 keystream, key[0] and frame[0] loaded first, 100 mixing steps discarded.
    function automatic logic [255:0] a5Model(input logic [63:0] k, input logic [21:0] f);
        logic [18:0]  a;
        logic [21:0]  b;
        logic [22:0]  c;
        logic         m;
        logic [255:0] out;
        a = '0; b = '0; c = '0; out = '0;
        for (int i = 0; i < 86; i++) begin
            logic lb;
            lb = (i < 64) ? k[i] : f[i-64];
            a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18] ^ lb};
            b = {b[20:0], b[20] ^ b[21] ^ lb};
            c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22] ^ lb};
        end
        for (int i = 0; i < 356; i++) begin
            m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
            if (a[8] == m)  a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18]};
            if (b[10] == m) b = {b[20:0], b[20] ^ b[21]};
            if (c[10] == m) c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22]};
            if (i >= 100) out[i-100] = a[18] ^ b[21] ^ c[22];
        end
        return out;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] k, input logic [21:0] f, input logic [255:0] c,
                                 input bit pushExp, input logic [255:0] expPt);
        bus.key   = k;
        bus.frame = f;
        bus.ct    = c;
        bus.start = 1'b1;
        if (pushExp) sb.push_back('{pt: expPt, ct: c, startCyc: cyc + 1});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitForDone(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got done=0 expected done=1 within 600 cycles", name);
        end
    endtask

    // Monitor: collect keystream pulses, and on each rising done compare against the scoreboard.
    initial begin
        exp_t e;
        prevDone = 1'b0;
        ksCount  = 0;
        ksBits   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ksCount = 0;
                ksBits  = '0;
            end else if (bus.ks_valid) begin
                if (ksCount < 256) ksBits[ksCount[7:0]] = bus.ks_bit;
                ksCount++;
            end
            if (bus.done && !prevDone) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no pending frame");
                end else begin
                    e = sb.pop_front();
                    checkOutput("pt", bus.pt, e.pt);
                    checkOutput("latency", 256'(cyc - e.startCyc), 256'(LATENCY));
                    checkOutput("ks_count", 256'(ksCount), 256'(256));
                    checkOutput("ks_vs_pt_ct", ksBits, e.pt ^ e.ct);
                end
                ksCount = 0;
                ksBits  = '0;
            end
            prevDone = bus.done;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        keyB   = 64'h0123456789ABCDEF;
        frameB = 22'h134;
        ksB    = a5Model(keyB, frameB);
        keyG   = 64'hFEDCBA9876543210;
        frameG = 22'h3FFFFF;
        ctG    = {8{32'hDEADBEEF}};
        ctE    = {8{32'h12345678}};
        patA5  = {32{8'hA5}};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.key   = '0;
        bus.frame = '0;
        bus.ct    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 256'(bus.busy), 256'(0));
        checkOutput("rst_done", 256'(bus.done), 256'(0));
        checkOutput("rst_pt", bus.pt, 256'(0));
        checkOutput("rst_ks_bit", 256'(bus.ks_bit), 256'(0));
        checkOutput("rst_ks_valid", 256'(bus.ks_valid), 256'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero key and frame keep the registers at zero, so plaintext equals ciphertext.
        applyStimulus(64'h0, 22'h0, patA5, 1'b1, patA5);
        waitForDone("zero_key");
        repeat (3) @(negedge clk);

        // Round trip: ct=0 exposes the keystream, ct=K must decrypt to zero.
        applyStimulus(keyB, frameB, 256'h0, 1'b1, ksB);
        waitForDone("keystream");
        repeat (2) @(negedge clk);
        applyStimulus(keyB, frameB, ksB, 1'b1, 256'h0);
        waitForDone("round_trip");
        repeat (2) @(negedge clk);

        // Start pulse and input changes while busy must not disturb the frame.
        applyStimulus(keyB, frameB, 256'h0, 1'b1, ksB);
        repeat (99) @(negedge clk);
        bus.key   = keyG;
        bus.frame = frameG;
        bus.ct    = ctG;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitForDone("start_while_busy");
        repeat (2) @(negedge clk);

        // Reset in STREAM at cnt=50 aborts the frame; no expectation is queued for it.
        startCycR = cyc + 1;
        applyStimulus(keyB, frameB, ctE, 1'b0, 256'h0);
        while (cyc < startCycR + 236) @(negedge clk);
        checkOutput("busy_before_rst", 256'(bus.busy), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 256'(bus.busy), 256'(0));
        checkOutput("abort_done", 256'(bus.done), 256'(0));
        checkOutput("abort_pt", bus.pt, 256'(0));
        checkOutput("abort_ks_valid", 256'(bus.ks_valid), 256'(0));
        @(negedge clk);
        applyStimulus(keyB, frameB, ctE, 1'b1, ctE ^ ksB);
        waitForDone("after_rst");

        // Back-to-back: start is raised in the same cycle done is first seen.
        applyStimulus(keyG, frameG, ctG, 1'b1, ctG ^ a5Model(keyG, frameG));
        checkOutput("b2b_done_drops", 256'(bus.done), 256'(0));
        checkOutput("b2b_busy", 256'(bus.busy), 256'(1));
        waitForDone("back_to_back");

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
